spi_shift_slave: RTL and testbench
==================================

Name: spi_shift_slave

Overview:
- Reusable SPI mode-0 slave shift stage sitting directly upstream of the job/device configuration registers in the external I/O path.
- One instance per SPI port:
  - SPI0 captures job configuration.
  - SPI1 captures device configuration and shifts out the shapool result.
- Synchronises the raw SPI pins into the system clock domain and frames transfers with cs_n.
- Passes data through to sdo so devices can be daisy-chained.
- Publishes a word only when exactly DATA_WIDTH bits were clocked in.

Parameters:
DATA_WIDTH, 8, shift register / published word width (>= 2)
SYNC_STAGES, 2, flip-flops in each pin synchroniser (>= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sck  input  1  raw SPI clock, mode 0: idle low, sample on rising edge
sdi  input  1  raw SPI data in, MSB first
cs_n  input  1  raw chip select, active low
sdo  output  1  serial data out; MSB of shift register, 0 when not selected
load  input  1  one-cycle pulse; preloads shift register with load_data (readback)
load_data  input  DATA_WIDTH  word to shift out on the next frame
data_out  output  DATA_WIDTH  last correctly framed word received
data_valid  output  1  one-cycle pulse when data_out updates
frame_error  output  1  one-cycle pulse on a frame ending with a bit count != DATA_WIDTH
busy  output  1  high while a frame is in progress

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high (`reset`). Every action below happens on rising clk.
- Reset values:
  - data_out=0, shift register=0, bit counter=0.
  - sdo=0, data_valid=0, frame_error=0, busy=0.
  - sck synchroniser=0, cs_n synchroniser=1, sdi synchroniser=0, FSM=IDLE.
- Synchronisation:
  - sck, sdi and cs_n each pass through SYNC_STAGES flip-flops, plus one history flip-flop for edge detection on sck and cs_n.
  - sdi uses the same stage depth, so it stays aligned with sck.
  - A pin edge is acted on SYNC_STAGES+1 clk cycles after it occurs.
- Minimum SPI timing: sck high and low each >= 3 clk cycles; cs_n setup/hold to sck >= 3 clk cycles.
- FSM, IDLE:
  - busy=0, sdo=0.
  - load=1 copies load_data into the shift register.
  - A synced cs_n falling edge clears the bit counter and moves to SHIFT.
  - If load coincides with the cs_n falling edge, the load takes effect and the frame then starts.
- FSM, SHIFT:
  - busy=1.
  - On each synced sck rising edge: shift register <= {shift[DATA_WIDTH-2:0], sdi_sync}.
  - Bit counter increments, saturating at DATA_WIDTH+1 (counter width clog2(DATA_WIDTH+2)).
  - load is ignored.
  - sdo is a registered copy of shift[DATA_WIDTH-1], updated every cycle, so the new MSB is valid <= SYNC_STAGES+3 cycles after the pin edge.
- FSM, end of frame (synced cs_n rising edge in SHIFT): return to IDLE next cycle.
  - bit count == DATA_WIDTH: data_out <= shift register, data_valid=1 for one cycle.
  - Any other count (short frame, or overrun > DATA_WIDTH): frame_error=1 for one cycle; data_out unchanged.
  - A sck rising edge detected in the same cycle as the cs_n rising edge is ignored.
- Overrun: shifting continues past DATA_WIDTH bits, so earlier bits emerge on sdo (daisy-chain pass-through). The frame is still flagged as an error.
- Reset mid-frame: the frame is aborted with no data_valid and no frame_error. After reset, a new frame requires a synced cs_n falling edge. If cs_n is held low through reset, no sck edges are honoured until cs_n has gone high then low.
- data_valid and frame_error are never high together and are never high in consecutive cycles for the same frame.

Decomposition:
- Shared package / header (shapool_io_defs):
  - FSM state encoding (IDLE, SHIFT).
  - Default SYNC_STAGES.
  - Minimum-SCK-half-period constant, used by benches.
- One sub-module: sync_edge (parameter STAGES; ports clk, reset, reset value, async_in, sync_out, rise, fall). Instantiated for sck and cs_n; sdi uses a plain STAGES-deep synchroniser.

Test Plan:
1. Reset, then an 8-bit frame with sdi=0xAA MSB first, sck half-period 4 clk -> exactly one data_valid pulse, data_out=0xAA, frame_error never high, busy falls after cs_n rises.
2. DATA_WIDTH=16: load with load_data=0x4141 in IDLE, then a 16-bit frame with sdi=0, master sampling sdo on each sck rise -> master captures 0x4141; data_out=0x0000 with data_valid pulse.
3. After scenario 1, a 5-bit frame -> one frame_error pulse, no data_valid, data_out stays 0xAA.
4. 16 bits (0xAA then 0x55) into an 8-bit instance -> sdo carries 0xAA during the second byte; frame_error pulses; data_out unchanged.
5. Assert reset after 3 bits with cs_n held low, release, continue toggling sck -> no data_valid or frame_error, busy=0. A subsequent cs_n high->low followed by 8 bits of 0x3C -> data_out=0x3C.
6. load pulse with load_data=0xFF mid-frame while shifting in 0x0F -> load ignored, data_out=0x0F, sdo never shows injected 0xFF bits.

Source files
------------

// File: rtl/spi_shift_slave_pkg.sv
// Shared definitions for the SPI shift slave and its benches.
//   state_t             : frame FSM encoding (idle / shifting)
//   DEFAULT_SYNC_STAGES : default depth of each pin synchroniser
//   MIN_SCK_HALF        : minimum sck high/low time in clk cycles
package spi_shift_slave_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int MIN_SCK_HALF        = 3;

endpackage

// File: rtl/spi_shift_slave_sync_edge.sv
// Multi-flop synchroniser with edge detection for one raw input pin.
//   clk, reset : system clock, synchronous active-high reset
//   rst_val    : value the chain and history flop take during reset
//   async_in   : raw pin
//   sync_out   : synchronised level (STAGES flops deep)
//   rise, fall : single-cycle edge strobes on the synchronised level
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{rst_val}};
            hist  <= rst_val;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            hist  <= chain[STAGES-1];
        end
    end

    assign sync_out = chain[STAGES-1];
    assign rise     = chain[STAGES-1] & ~hist;
    assign fall     = ~chain[STAGES-1] & hist;

endmodule

// File: rtl/spi_shift_slave.sv
// SPI mode-0 slave shift stage (one per SPI port).
//   clk, reset  : system clock, synchronous active-high reset
//   sck,sdi,cs_n: raw SPI pins (sampled on synced sck rise, MSB first)
//   sdo         : MSB of the shift register while selected, else 0
//   load        : in idle, preloads shift register with load_data
//   data_out    : last word received with exactly DATA_WIDTH bits
//   data_valid  : one-cycle pulse when data_out updates
//   frame_error : one-cycle pulse when a frame ends with a wrong bit count
//   busy        : high while a frame is in progress
module spi_shift_slave
    import spi_shift_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  cs_n,
    output logic                  sdo,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CNT_W   = $clog2(DATA_WIDTH + 2);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(DATA_WIDTH + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(SYNC_STAGES + 1);

    logic sck_rise, unused_sck_fall, unused_sck_sync;
    logic cs_sync, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] sdi_chain;
    logic sdi_sync;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk      (clk),
        .reset    (reset),
        .rst_val  (1'b0),
        .async_in (sck),
        .sync_out (unused_sck_sync),
        .rise     (sck_rise),
        .fall     (unused_sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk      (clk),
        .reset    (reset),
        .rst_val  (1'b1),
        .async_in (cs_n),
        .sync_out (cs_sync),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // sdi gets the same depth as sck so the sampled bit lines up with the edge
    always_ff @(posedge clk) begin
        if (reset) sdi_chain <= '0;
        else       sdi_chain <= {sdi_chain[SYNC_STAGES-2:0], sdi};
    end
    assign sdi_sync = sdi_chain[SYNC_STAGES-1];

    // The cs_n chain resets high, so a pin held low through reset would
    // produce a false falling edge while the chain flushes. Frames are only
    // accepted once the flushed chain has shown cs_n high.
    logic [FLUSH_W-1:0] flush_cnt;
    logic               cs_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= '0;
            cs_armed  <= 1'b0;
        end else begin
            if (flush_cnt != FLUSH_END)
                flush_cnt <= flush_cnt + FLUSH_W'(1);
            else if (cs_sync)
                cs_armed <= 1'b1;
        end
    end

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_out_d;
    logic                  valid_d, ferr_d, sdo_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            sdo         <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            data_out    <= data_out_d;
            data_valid  <= valid_d;
            frame_error <= ferr_d;
            sdo         <= sdo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        data_out_d = data_out;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        sdo_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load)
                    shift_d = load_data;
                if (cs_fall && cs_armed) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sdo_d = shift_q[DATA_WIDTH-1];
                // end of frame takes priority over a coincident sck edge
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_q == CNT_FULL) begin
                        data_out_d = shift_q;
                        valid_d    = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else if (sck_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], sdi_sync};
                    if (cnt_q != CNT_SAT)
                        cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_shift_slave.sv
module tb_spi_shift_slave;
    import spi_shift_slave_pkg::*;

    localparam int HALF  = MIN_SCK_HALF + 1;
    localparam int SETUP = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       sck8 = 0, sdi8 = 0, cs8 = 1, load8 = 0;
    logic [7:0] ld8 = 0;
    logic       sdo8, dv8, fe8, busy8;
    logic [7:0] dout8;

    // 16-bit instance
    logic        sck16 = 0, sdi16 = 0, cs16 = 1, load16 = 0;
    logic [15:0] ld16 = 0;
    logic        sdo16, dv16, fe16, busy16;
    logic [15:0] dout16;

    spi_shift_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .sck(sck8), .sdi(sdi8), .cs_n(cs8),
        .sdo(sdo8), .load(load8), .load_data(ld8), .data_out(dout8),
        .data_valid(dv8), .frame_error(fe8), .busy(busy8)
    );

    spi_shift_slave #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .reset(reset), .sck(sck16), .sdi(sdi16), .cs_n(cs16),
        .sdo(sdo16), .load(load16), .load_data(ld16), .data_out(dout16),
        .data_valid(dv16), .frame_error(fe16), .busy(busy16)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // pulse / level counters, only ever incremented here
    int vld8_cnt = 0, fe8_cnt = 0, busy8_cnt = 0, both8_cnt = 0;
    int vld16_cnt = 0, fe16_cnt = 0;
    always @(negedge clk) begin
        if (dv8)         vld8_cnt++;
        if (fe8)         fe8_cnt++;
        if (busy8)       busy8_cnt++;
        if (dv8 && fe8)  both8_cnt++;
        if (dv16)        vld16_cnt++;
        if (fe16)        fe16_cnt++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Runs one frame on instance sel (8 or 16). Captures sdo just before each
    // sck rise. load_bit >= 0 pulses load before that bit's rising edge.
    task automatic spi_frame(input int sel, input logic [15:0] word, input int nbits,
                             input int load_bit, input logic [15:0] ld_val,
                             output logic [15:0] cap, output logic busy_mid);
        cap = '0;
        if (sel == 8) cs8 = 0; else cs16 = 0;
        wait_clk(SETUP);
        for (int i = 0; i < nbits; i++) begin
            if (sel == 8) sdi8 = word[nbits-1-i]; else sdi16 = word[nbits-1-i];
            wait_clk(HALF);
            if (i == load_bit) begin
                if (sel == 8) begin ld8 = ld_val[7:0]; load8 = 1; end
                else begin ld16 = ld_val; load16 = 1; end
                wait_clk(1);
                load8 = 0; load16 = 0;
            end
            cap = {cap[14:0], (sel == 8) ? sdo8 : sdo16};
            if (sel == 8) sck8 = 1; else sck16 = 1;
            wait_clk(HALF);
            if (sel == 8) sck8 = 0; else sck16 = 0;
        end
        wait_clk(SETUP);
        busy_mid = (sel == 8) ? busy8 : busy16;
        if (sel == 8) cs8 = 1; else cs16 = 1;
        wait_clk(10);
    endtask

    task automatic test_reset;
        reset = 1;
        wait_clk(4);
        check("reset_data_out", {24'd0, dout8}, 32'h0);
        check("reset_sdo", {31'd0, sdo8}, 32'h0);
        check("reset_busy", {31'd0, busy8}, 32'h0);
        check("reset_valid_err", {30'd0, dv8, fe8}, 32'h0);
        check("reset_data_out16", {16'd0, dout16}, 32'h0);
        reset = 0;
        wait_clk(10);
    endtask

    task automatic test_basic_frame;
        logic [15:0] cap; logic bm;
        int v0 = vld8_cnt, f0 = fe8_cnt;
        spi_frame(8, 16'h00AA, 8, -1, 16'h0, cap, bm);
        check("t1_valid_pulses", vld8_cnt - v0, 1);
        check("t1_err_pulses", fe8_cnt - f0, 0);
        check("t1_data_out", {24'd0, dout8}, 32'hAA);
        check("t1_busy_mid", {31'd0, bm}, 32'h1);
        check("t1_busy_after", {31'd0, busy8}, 32'h0);
    endtask

    task automatic test_short_frame;
        logic [15:0] cap; logic bm;
        int v0 = vld8_cnt, f0 = fe8_cnt;
        spi_frame(8, 16'h0016, 5, -1, 16'h0, cap, bm);
        check("t3_err_pulses", fe8_cnt - f0, 1);
        check("t3_valid_pulses", vld8_cnt - v0, 0);
        check("t3_data_out", {24'd0, dout8}, 32'hAA);
    endtask

    task automatic test_overrun;
        logic [15:0] cap; logic bm;
        int v0 = vld8_cnt, f0 = fe8_cnt;
        spi_frame(8, 16'hAA55, 16, -1, 16'h0, cap, bm);
        check("t4_sdo_passthrough", {24'd0, cap[7:0]}, 32'hAA);
        check("t4_err_pulses", fe8_cnt - f0, 1);
        check("t4_valid_pulses", vld8_cnt - v0, 0);
        check("t4_data_out", {24'd0, dout8}, 32'hAA);
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] cap; logic bm;
        int v0, f0, b0;
        logic [7:0] w = 8'b1010_0000;
        cs8 = 0;
        wait_clk(SETUP);
        for (int i = 0; i < 3; i++) begin
            sdi8 = w[7-i];
            wait_clk(HALF); sck8 = 1; wait_clk(HALF); sck8 = 0;
        end
        reset = 1;
        wait_clk(2);
        reset = 0;
        v0 = vld8_cnt; f0 = fe8_cnt; b0 = busy8_cnt;
        check("t5_data_out_reset", {24'd0, dout8}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            sdi8 = i[0];
            wait_clk(HALF); sck8 = 1; wait_clk(HALF); sck8 = 0;
        end
        wait_clk(SETUP);
        cs8 = 1;
        wait_clk(10);
        check("t5_no_valid", vld8_cnt - v0, 0);
        check("t5_no_err", fe8_cnt - f0, 0);
        check("t5_never_busy", busy8_cnt - b0, 0);
        v0 = vld8_cnt;
        spi_frame(8, 16'h003C, 8, -1, 16'h0, cap, bm);
        check("t5_valid_after", vld8_cnt - v0, 1);
        check("t5_data_out", {24'd0, dout8}, 32'h3C);
    endtask

    task automatic test_load_ignored;
        logic [15:0] cap; logic bm;
        int v0 = vld8_cnt;
        // shift register holds 0x3C from the previous frame
        spi_frame(8, 16'h000F, 8, 3, 16'h00FF, cap, bm);
        check("t6_data_out", {24'd0, dout8}, 32'h0F);
        check("t6_valid_pulses", vld8_cnt - v0, 1);
        check("t6_sdo_stream", {24'd0, cap[7:0]}, 32'h3C);
    endtask

    task automatic test_readback16;
        logic [15:0] cap; logic bm;
        int v0 = vld16_cnt, f0 = fe16_cnt;
        ld16 = 16'h4141; load16 = 1;
        wait_clk(1);
        load16 = 0;
        wait_clk(3);
        spi_frame(16, 16'h0000, 16, -1, 16'h0, cap, bm);
        check("t2_master_capture", {16'd0, cap}, 32'h4141);
        check("t2_data_out", {16'd0, dout16}, 32'h0);
        check("t2_valid_pulses", vld16_cnt - v0, 1);
        check("t2_err_pulses", fe16_cnt - f0, 0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_short_frame();
        test_overrun();
        test_reset_mid_frame();
        test_load_ignored();
        test_readback16();
        check("never_valid_and_err", both8_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
